// File: rtl/fifo_async_pkg.sv
// Shared helpers for both pointer domains of the async FIFO.
// Gray/binary conversion and the default depth constant.
package fifo_async_pkg;

  localparam int FIFO_ABITS = 10;
  localparam int FIFO_DEPTH = 1 << FIFO_ABITS;

  // Operands are zero-extended, so one 32-bit form serves every width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clocks.
// Shared by the read and write pointer generators.
module fifo_ptr_sync #(
  parameter int WIDTH       = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_wptr_full_gen.sv
// Write-side pointer, RAM write port and full/level flags
// of the async FIFO, all in the wrclk domain.
module fifo_wptr_full_gen
  import fifo_async_pkg::*;
#(
  parameter int          ABITS        = 10,
  parameter int          DBITS        = 16,
  parameter int          SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = (1 << ABITS) - 4
) (
  input  logic             wrclk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wr_data,
  input  logic [ABITS:0]   rd_gray_ptr,
  output logic             w_en,
  output logic [ABITS-1:0] w_addr,
  output logic [DBITS-1:0] w_data,
  output logic [ABITS-1:0] wr_bin_ptr,
  output logic [ABITS:0]   wr_gray_ptr,
  output logic             wr_full,
  output logic             wr_almost_full,
  output logic [ABITS:0]   wr_usedw,
  output logic             wr_overflow
);

  localparam int PW = ABITS + 1;
  localparam logic [PW-1:0] AF = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rgray_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] level_next;
  logic          wr_allow;

  fifo_ptr_sync #(
    .WIDTH       (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rsync (
    .clk (wrclk),
    .rst (rst),
    .d   (rd_gray_ptr),
    .q   (rgray_s)
  );

  always_comb begin
    wr_allow   = wr_en & ~wr_full;
    wbin_next  = wbin + PW'(wr_allow);
    wgray_next = PW'(bin2gray(32'(wbin_next)));
    rbin_s     = PW'(gray2bin(32'(rgray_s)));
    // Full when the write pointer laps the read pointer by one depth.
    full_cmp   = {~rgray_s[ABITS:ABITS-1], rgray_s[ABITS-2:0]};
    level_next = wbin_next - rbin_s;
  end

  assign w_en       = wr_allow & ~rst;
  assign w_addr     = wbin[ABITS-1:0];
  assign w_data     = wr_data;
  assign wr_bin_ptr = wbin[ABITS-1:0];

  always_ff @(posedge wrclk) begin
    if (rst) begin
      wbin           <= '0;
      wr_gray_ptr    <= '0;
      wr_full        <= 1'b0;
      wr_almost_full <= 1'b0;
      wr_usedw       <= '0;
      wr_overflow    <= 1'b0;
    end else begin
      wbin           <= wbin_next;
      wr_gray_ptr    <= wgray_next;
      wr_full        <= (wgray_next == full_cmp);
      wr_almost_full <= (level_next >= AF);
      wr_usedw       <= level_next;
      wr_overflow    <= wr_overflow | (wr_en & wr_full);
    end
  end

endmodule
